conv_out_collector: RTL and testbench

//  Receiving end of the 3x3 convolution output stream. Accepts the sparse
//  pxl_in/valid_in stream (valid only on the D*D interior pixels of each frame).

---
 rtl/conv_out_collector.sv | 157 +++++++++++++++
 tb/tb_conv_out_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_collector.sv
// rtl/conv_out_collector.sv - frame buffer that captures a DxD conv output frame and replays it in raster order
//
// Purpose:
//   Captures the sparse conv result stream (valid_in/pxl_in) into a D*D word
//   frame buffer, optionally clamping negative pixels to zero (RELU=1). Once
//   the frame is complete it is replayed in raster order over a valid/ready
//   interface. The frame is captured, then replayed, then the block returns to
//   capturing.
//
// Ports:
//   clk           in   clock, all logic on rising edge
//   reset         in   synchronous, active-high
//   valid_in      in   pxl_in carries a conv result this cycle
//   pxl_in        in   conv result pixel (two's complement)
//   out_ready     in   downstream accepts pxl_out this cycle
//   out_valid     out  pxl_out holds a buffered pixel
//   pxl_out       out  buffered pixel, raster order
//   out_last_col  out  pxl_out is the last pixel of a row
//   out_last      out  pxl_out is the last pixel of the frame
//   busy          out  block is not capturing input (LOAD/DRAIN)
//   frame_done    out  1-cycle pulse after the final output handshake
//   overrun       out  sticky: valid_in arrived while not capturing
module conv_out_collector #(
  parameter int D          = 220,
  parameter int DATA_WIDTH = 32,
  parameter int RELU       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  out_last_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam int NPIX = D * D;
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = (D > 1) ? $clog2(D) : 1;

  localparam logic [PW-1:0] LAST_PTR = PW'(NPIX - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(D - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] pxl_q;

  logic [DATA_WIDTH-1:0] mem [NPIX];
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;
  logic [PW-1:0]         rd_addr;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    col_d        = col_q;
    frame_done_d = 1'b0;
    // Any sample arriving outside FILL is dropped, including one coinciding
    // with the final output handshake.
    overrun_d    = overrun_q | (valid_in && (state_q != S_FILL));
    mem_we       = 1'b0;
    mem_wdata    = ((RELU != 0) && pxl_in[DATA_WIDTH-1]) ? '0 : pxl_in;
    rd_en        = 1'b0;
    rd_addr      = rd_ptr_q;

    case (state_q)
      S_FILL: begin
        if (valid_in) begin
          mem_we = 1'b1;
          if (wr_ptr_q == LAST_PTR) begin
            wr_ptr_d = '0;
            state_d  = S_LOAD;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_LOAD: begin
        // Prefetch pixel 0 so it is on pxl_out when out_valid first rises.
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == LAST_PTR) begin
            state_d      = S_FILL;
            rd_ptr_d     = '0;
            col_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            // Fetch the next pixel during the handshake cycle so a held-high
            // out_ready streams one pixel per cycle.
            rd_en    = 1'b1;
            rd_addr  = rd_ptr_q + 1'b1;
            rd_ptr_d = rd_ptr_q + 1'b1;
            col_d    = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      pxl_q        <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      if (rd_en) begin
        pxl_q <= mem[rd_addr];
      end
    end
  end

  // Buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[wr_ptr_q] <= mem_wdata;
    end
  end

  assign out_valid    = (state_q == S_DRAIN);
  assign pxl_out      = pxl_q;
  assign out_last_col = out_valid && (col_q == LAST_COL);
  assign out_last     = out_valid && (rd_ptr_q == LAST_PTR);
  assign busy         = (state_q != S_FILL);
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// tb/tb_conv_out_collector.sv - randomized self-checking bench for conv_out_collector against a queue-based frame model
module tb_conv_out_collector;
  localparam int D  = 4;
  localparam int DW = 32;
  localparam int N  = D * D;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic          out_ready;

  logic          out_valid_n, out_last_col_n, out_last_n, busy_n, frame_done_n, overrun_n;
  logic [DW-1:0] pxl_out_n;
  logic          out_valid_r, out_last_col_r, out_last_r, busy_r, frame_done_r, overrun_r;
  logic [DW-1:0] pxl_out_r;

  conv_out_collector #(.D(D), .DATA_WIDTH(DW), .RELU(0)) u_dut_n (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .out_ready(out_ready),
    .out_valid(out_valid_n), .pxl_out(pxl_out_n), .out_last_col(out_last_col_n),
    .out_last(out_last_n), .busy(busy_n), .frame_done(frame_done_n), .overrun(overrun_n)
  );

  conv_out_collector #(.D(D), .DATA_WIDTH(DW), .RELU(1)) u_dut_r (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in), .out_ready(out_ready),
    .out_valid(out_valid_r), .pxl_out(pxl_out_r), .out_last_col(out_last_col_r),
    .out_last(out_last_r), .busy(busy_r), .frame_done(frame_done_r), .overrun(overrun_r)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
    return x[DW-1] ? '0 : x;
  endfunction

  // Reference model: phase 0 = capturing, 1 = one-cycle prefetch, 2 = replaying
  int            m_phase;
  logic [DW-1:0] cap_n[$];
  logic [DW-1:0] cap_r[$];
  logic [DW-1:0] frm_n[N];
  logic [DW-1:0] frm_r[N];
  int            m_idx;
  bit            m_ovr;
  bit            m_fd;

  logic [DW-1:0] got_n[$];
  logic [DW-1:0] got_r[$];
  logic [DW-1:0] pix[N];

  task automatic model_update(input bit rst, input bit vin, input logic [DW-1:0] din, input bit rdy);
    if (rst) begin
      m_phase = 0; m_idx = 0; m_ovr = 0; m_fd = 0;
      cap_n.delete(); cap_r.delete();
      return;
    end
    m_fd = 0;
    if (m_phase == 0) begin
      if (vin) begin
        cap_n.push_back(din);
        cap_r.push_back(relu(din));
        if (cap_n.size() == N) begin
          for (int i = 0; i < N; i++) begin
            frm_n[i] = cap_n[i];
            frm_r[i] = cap_r[i];
          end
          cap_n.delete(); cap_r.delete();
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (vin) m_ovr = 1;
      m_phase = 2;
      m_idx   = 0;
    end else begin
      if (vin) m_ovr = 1;
      if (rdy) begin
        if (m_idx == N - 1) begin
          m_phase = 0;
          m_fd    = 1;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (m_phase == 2);
    check_val("out_valid", 32'(out_valid_n), 32'(ev));
    check_val("out_valid_relu", 32'(out_valid_r), 32'(ev));
    if (ev) begin
      check_val("pxl_out", pxl_out_n, frm_n[m_idx]);
      check_val("pxl_out_relu", pxl_out_r, frm_r[m_idx]);
    end
    check_val("out_last_col", 32'(out_last_col_n), 32'(ev && (m_idx % D == D - 1)));
    check_val("out_last", 32'(out_last_n), 32'(ev && (m_idx == N - 1)));
    check_val("busy", 32'(busy_n), 32'(m_phase != 0));
    check_val("frame_done", 32'(frame_done_n), 32'(m_fd));
    check_val("overrun", 32'(overrun_n), 32'(m_ovr));
    check_val("overrun_relu", 32'(overrun_r), 32'(m_ovr));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit rst, input bit vin, input logic [DW-1:0] din, input bit rdy);
    reset     = rst;
    valid_in  = vin;
    pxl_in    = din;
    out_ready = rdy;
    if (!rst && out_valid_n === 1'b1 && rdy) got_n.push_back(pxl_out_n);
    if (!rst && out_valid_r === 1'b1 && rdy) got_r.push_back(pxl_out_r);
    model_update(rst, vin, din, rdy);
    @(negedge clk);
    if (rst) begin
      check_val("reset_pxl_out", pxl_out_n, 32'h0);
      check_val("reset_pxl_out_relu", pxl_out_r, 32'h0);
    end
    check_outputs();
  endtask

  // gap_mode: 0 continuous, 1 two idle cycles of every six, 2 random
  // rdy_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random
  task automatic run_frame(input int gap_mode, input int rdy_mode, input bit inject);
    int  sent;
    int  k;
    int  cnt;
    bit  vin;
    bit  rdy;
    sent = 0; k = 0; cnt = 0;
    got_n.delete(); got_r.delete();
    while (sent < N && k < 500) begin
      case (gap_mode)
        0:       vin = 1'b1;
        1:       vin = (k % 6) < 4;
        default: vin = ($urandom_range(0, 3) != 0);
      endcase
      if (vin) begin
        step(1'b0, 1'b1, pix[sent], 1'b1);
        sent++;
      end else begin
        step(1'b0, 1'b0, $urandom, 1'b1);
      end
      k++;
    end
    while (frame_done_n !== 1'b1 && cnt < 500) begin
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cnt % 4 == 0) || (cnt % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      step(1'b0, inject && (cnt == 3), 32'd99, rdy);
      cnt++;
    end
    check_val("frame_done_within_bound", 32'(cnt < 500), 32'd1);
    check_val("handshake_count", 32'(got_n.size()), 32'(N));
    check_val("handshake_count_relu", 32'(got_r.size()), 32'(N));
    for (int i = 0; i < N && i < got_n.size(); i++) check_val("seq", got_n[i], pix[i]);
    for (int i = 0; i < N && i < got_r.size(); i++) check_val("seq_relu", got_r[i], relu(pix[i]));
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Continuous stream 1..16, always ready
    for (int i = 0; i < N; i++) pix[i] = 32'(i + 1);
    run_frame(0, 0, 1'b0);

    // Padding gaps on input
    run_frame(1, 0, 1'b0);

    // Back-pressure pattern during replay
    run_frame(0, 1, 1'b0);

    // Alternating positive / negative pixels for ReLU behaviour
    for (int i = 0; i < N; i++) pix[i] = (i % 2 == 0) ? 32'd5 : 32'hFFFF_FFFD;
    run_frame(1, 0, 1'b0);

    // Stray sample during replay sets overrun; following frame unaffected
    for (int i = 0; i < N; i++) pix[i] = 32'(i + 1);
    run_frame(0, 0, 1'b1);
    for (int i = 0; i < N; i++) pix[i] = $urandom;
    run_frame(2, 2, 1'b0);

    // Reset mid-frame, then a clean frame 101..116
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 32'(200 + i), 1'b1);
    step(1'b1, 1'b1, 32'd77, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < N; i++) pix[i] = 32'(101 + i);
    run_frame(0, 0, 1'b0);

    // Randomized frames with random gaps, back-pressure and stray samples
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) pix[i] = $urandom;
      run_frame(2, 2, (f == 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
